tf_fifo_writer: RTL

- Producer side of the twiddle-factor FIFO in each radix stage of the FFT pipeline.
- On a start pulse, reads a programmed run of complex twiddle factors (re/im packed, 2*float_len bits) from a synchronous-read BRAM with strided addressing.
- Pushes each factor into the downstream stage FIFO through its wr_en/full interface, in order, without loss and at up to one word per cycle.

---
 rtl/tf_fifo_writer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tf_fifo_writer.sv
// tf_fifo_writer: producer side of the per-stage twiddle-factor FIFO.
// A start pulse launches a run of strided reads from a synchronous-read BRAM.
// Returned words pass through a 2-entry skid buffer, and the head of that buffer
// drives the downstream FIFO write port.
// Reads are throttled so that the data already buffered plus the data in flight
// from the BRAM never exceeds two words. This allows one word per cycle when
// the FIFO has room, and no data is lost when fifo_full asserts.
module tf_fifo_writer #(
    parameter int float_len     = 32,
    parameter int bram_addr_len = 13,
    parameter int cnt_len       = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [bram_addr_len-1:0] tf_base,
    input  logic [bram_addr_len-1:0] tf_stride,
    input  logic [cnt_len-1:0]       tf_count,
    output logic                     bram_en,
    output logic [bram_addr_len-1:0] bram_addr,
    input  logic [2*float_len-1:0]   bram_dout,
    output logic [2*float_len-1:0]   fifo_din,
    output logic                     fifo_wr_en,
    input  logic                     fifo_full,
    output logic                     busy,
    output logic                     done
);

    localparam int W = 2 * float_len;
    localparam logic [cnt_len-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                   state;
    logic [bram_addr_len-1:0] addr;
    logic [bram_addr_len-1:0] stride_q;
    logic [cnt_len-1:0]       issue_cnt;
    logic [cnt_len-1:0]       remaining;
    logic [1:0]               occ;
    logic                     rd_pend;
    logic [W-1:0]             buf0;
    logic [W-1:0]             buf1;
    logic                     accept;
    logic [2:0]               level;

    assign fifo_wr_en = (occ != 2'd0);
    assign fifo_din   = buf0;
    assign accept     = fifo_wr_en & ~fifo_full;
    assign bram_addr  = addr;

    // Words buffered plus the word returning from the BRAM next edge.
    // A new read may issue only if, after this cycle's pop, one slot stays free.
    assign level   = {1'b0, occ} + {2'b0, rd_pend};
    assign bram_en = (state == RUN) && (issue_cnt != '0) &&
                     (level < (3'd2 + {2'b0, accept}));

    // Control FSM: latch the run on start, walk addresses, count accepts, pulse done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            stride_q  <= '0;
            issue_cnt <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr      <= tf_base;
                        stride_q  <= tf_stride;
                        issue_cnt <= tf_count;
                        remaining <= tf_count;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (bram_en) begin
                        addr      <= addr + stride_q;
                        issue_cnt <= issue_cnt - CNT_ONE;
                    end
                    if (accept) begin
                        remaining <= remaining - CNT_ONE;
                    end
                    // An empty run finishes one cycle after start.
                    // Otherwise the run finishes on the edge that accepts the last word.
                    if ((remaining == '0) || (accept && (remaining == CNT_ONE))) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Skid buffer: push the returning BRAM word at the tail, pop the head on accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend <= 1'b0;
            occ     <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            rd_pend <= bram_en;
            case ({rd_pend, accept})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0 <= bram_dout;
                    end else begin
                        buf1 <= bram_dout;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= bram_dout;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= bram_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
